// File: rtl/audio_sample_pacer_if.sv
// Purpose: producer-side push bus for audio_sample_pacer (one stereo pair per accepted beat).
// Latency: n/a (wires only).
// Backpressure: in_ready reflects FIFO space; a producer may ignore it and lose the pair.
interface audio_sample_pacer_if #(
    parameter int SAMPLE_W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;

    // Producer side drives the pair, observes ready.
    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    // Pacer side consumes the pair, drives ready.
    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );
endinterface

// File: rtl/audio_sample_pacer.sv
// Purpose: stereo sample FIFO plus rate divider feeding the I2S/DSP serializer; optional macro AUDIO_PACER_UNDERRUN_MUTE_EN mutes outputs on underrun.
// Latency: a pair pushed into an empty FIFO reaches the outputs at the next tick (1..DIVIDER cycles).
// Backpressure: in_ready = level < depth (registered level only); pushes while full are dropped and counted.
module audio_sample_pacer #(
    parameter int DIVIDER    = 500,
    parameter int DEPTH_LOG2 = 4,
    parameter int SAMPLE_W   = 16
) (
    input  logic                  clk25,
    input  logic                  reset25_n,
    input  logic                  enable,
    audio_sample_pacer_if.slave   push,
    output logic [SAMPLE_W-1:0]   audio_left_sample,
    output logic [SAMPLE_W-1:0]   audio_right_sample,
    output logic                  audio_sample_clk,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [15:0]           underrun_cnt,
    output logic [15:0]           overflow_cnt
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam int                  CNT_W      = $clog2(DIVIDER);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0]    CNT_HALF   = CNT_W'(DIVIDER / 2);
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    tick;
    logic                    do_push;
    logic                    do_pop;
    logic                    drop;
    logic                    fifo_empty;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [2*SAMPLE_W-1:0]   mem [DEPTH];
    logic [2*SAMPLE_W-1:0]   head;

    // Ready comes only from the registered level, so a pop never opens a same-cycle push slot.
    assign push.in_ready = (fifo_level < LEVEL_FULL);
    assign fifo_empty    = (fifo_level == '0);
    assign tick          = enable && (cnt == CNT_LAST);
    assign do_push       = push.in_valid && push.in_ready;
    assign drop          = push.in_valid && !push.in_ready;
    assign do_pop        = tick && !fifo_empty;
    assign head          = mem[rd_ptr];

    // Divider next state: parked at the last count while paused so resuming ticks at once.
    always_comb begin
        cnt_nxt = CNT_LAST;
        if (enable) begin
            cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Divider count and registered strobe; strobe is high for the first half of each period.
    always_ff @(posedge clk25 or negedge reset25_n) begin
        if (!reset25_n) begin
            cnt              <= CNT_LAST;
            audio_sample_clk <= 1'b0;
        end else begin
            cnt              <= cnt_nxt;
            audio_sample_clk <= enable && (cnt_nxt < CNT_HALF);
        end
    end

    // Sample storage; contents need no reset since level/pointers gate every read.
    always_ff @(posedge clk25) begin
        if (do_push) begin
            mem[wr_ptr] <= {push.in_left, push.in_right};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk25 or negedge reset25_n) begin
        if (!reset25_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Output pair register; updates only on a tick so data is stable for a full period.
    always_ff @(posedge clk25 or negedge reset25_n) begin
        if (!reset25_n) begin
            audio_left_sample  <= '0;
            audio_right_sample <= '0;
        end else if (do_pop) begin
            audio_left_sample  <= head[2*SAMPLE_W-1:SAMPLE_W];
            audio_right_sample <= head[SAMPLE_W-1:0];
        end else if (tick) begin
`ifdef AUDIO_PACER_UNDERRUN_MUTE_EN
            // Underrun: emit silence rather than repeating the stale pair.
            audio_left_sample  <= '0;
            audio_right_sample <= '0;
`else
            // Underrun: hold the last popped pair.
            audio_left_sample  <= audio_left_sample;
            audio_right_sample <= audio_right_sample;
`endif
        end
    end

    // Saturating error counters: empty ticks and dropped pushes.
    always_ff @(posedge clk25 or negedge reset25_n) begin
        if (!reset25_n) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (tick && fifo_empty && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/audio_sample_pacer.md
Name: audio_sample_pacer

Overview:
- Stereo sample buffer and rate generator upstream of the I2S/DSP codec serializer.
- Accepts 16-bit L/R sample pairs from the OPL3 synth core at its native, bursty rate and stores them in a small FIFO.
- Emits one pair per DIVIDER clk25 cycles (500 → 50 kHz), together with audio_sample_clk whose rising edge tells the serializer to start a frame.
- Holds each output pair stable for the full sample period so the serializer can read bits at any BCLK edge.

Parameters:
- DIVIDER, 500: clk25 cycles per output sample; legal range ≥ 128 (the serializer needs ≥ 64 cycles of stable data).
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 stereo pairs.
- SAMPLE_W, 16: bits per channel.

Ports:
- clk25  in  1  sole clock, 25 MHz.
- reset25_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = pacing runs; 0 = pacing paused.
- in_valid  in  1  producer offers a pair this cycle.
- in_ready  out  1  FIFO can accept this cycle.
- in_left  in  SAMPLE_W  left sample, two's complement.
- in_right  in  SAMPLE_W  right sample.
- audio_left_sample  out  SAMPLE_W  registered left output to the serializer.
- audio_right_sample  out  SAMPLE_W  registered right output.
- audio_sample_clk  out  1  sample strobe; rising edge marks new data.
- fifo_level  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- underrun_cnt  out  16  saturating count of ticks that found the FIFO empty.
- overflow_cnt  out  16  saturating count of dropped pushes.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, FIFO empty, both counters 0.
  - Divider count cnt = DIVIDER-1.
- Push side:
  - in_ready = (fifo_level < 2^DEPTH_LOG2), combinational from registered level only.
  - Push accepted iff in_valid && in_ready. Data is written at the write pointer, which then advances (wraps at depth).
  - in_valid && !in_ready drops the pair and increments overflow_cnt; saturates at 16'hFFFF. The producer may ignore in_ready.
- Divider:
  - When enable=1: cnt counts DIVIDER-1 → 0 → 1 … → DIVIDER-1, wrapping.
  - When enable=0: cnt is forced to DIVIDER-1, audio_sample_clk is forced to 0, and no pops occur. Pushes still operate.
  - Tick: a cycle with enable=1 and cnt==DIVIDER-1. The first cycle after enable rises is therefore a tick.
- At a tick (the registers update on the same edge):
  - cnt → 0.
  - audio_sample_clk → 1.
  - If the FIFO is non-empty: pop the head into audio_left_sample and audio_right_sample, and advance the read pointer.
  - If the FIFO is empty: increment underrun_cnt (saturating) and leave the outputs at their previous value; see Optional Feature.
- audio_sample_clk is registered and equals 1 for cnt < DIVIDER/2 (integer division), else 0.
  - One rising edge per DIVIDER cycles.
  - The edge coincides with the output-data update; data is stable for DIVIDER cycles.
- Simultaneous push and pop:
  - Both take effect and fifo_level is unchanged.
  - When full, in_ready was already 0, so the push is dropped even though a pop frees a slot. This is intentional: there is no combinational ready path.
- Push into an empty FIFO on a tick cycle: there is no bypass. The tick is counted as an underrun and the pushed pair is popped on the next tick.
- Latency: a pair accepted into an empty FIFO appears on the outputs at the next tick (1..DIVIDER cycles later).
- Reset mid-operation: FIFO contents are discarded and the outputs return to 0 immediately (asynchronously).

Optional Feature:
- Macro: AUDIO_PACER_UNDERRUN_MUTE_EN.
- Defined: on an underrun tick both outputs load 0 (silence).
- Undefined: on an underrun tick the outputs hold the last popped pair.
- underrun_cnt counts identically in both builds.

Test Plan:
- Reset, enable=1, no pushes:
  - audio_sample_clk rises at cycles 1, 501, 1001.
  - High for 250 cycles each period.
  - underrun_cnt = 3 after 1001 cycles; outputs stay 0.
- With enable=0, push 3 pairs (L=16'h1111/2222/3333, R=16'hAAAA/BBBB/CCCC), then raise enable:
  - Outputs show 1111/AAAA at the first tick, 2222/BBBB 500 cycles later, then 3333/CCCC.
  - fifo_level steps 3 → 2 → 1 → 0.
- Hold in_valid=1 for 20 cycles with enable=0:
  - in_ready falls after 16 accepts; fifo_level = 16; overflow_cnt = 4.
- Full FIFO, push held on a tick cycle:
  - Pop occurs and the push is dropped.
  - fifo_level becomes 15 and overflow_cnt increments by 1.
- Underrun after data 16'h7FFF/16'h8000:
  - Without the macro, outputs remain 7FFF/8000.
  - With AUDIO_PACER_UNDERRUN_MUTE_EN, outputs become 0/0.
  - underrun_cnt increments in both builds.
- Assert reset25_n=0 mid-period with 5 entries queued:
  - Outputs, level and counters go to 0 immediately.
  - After release, the first tick occurs on the first enabled cycle.
